fetch_controller: RTL

//  Sequencer for the custom processor's instruction memory. Owns the program counter and drives
//  the memory address. Latches each fetched word into an instruction register and hands it to
//  the execute stage over a valid/ready handshake. Applies jumps, wraps the PC, detects the halt

---
 rtl/proc_pkg.sv | 14 +
 rtl/pc_counter.sv | 30 +++
 rtl/fetch_controller.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// Shared types and constants for the processor front end.
// Fetch FSM encoding and the default halt opcode.
package proc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE,
    HALT
  } fetch_state_t;

  localparam logic [7:0] HALT_OP_DEFAULT = 8'hFF;

endpackage

// File: rtl/pc_counter.sv
// Program counter register with clear, load and wrapping increment.
// Wraps at DEPTH-1 so non-power-of-two memories never see a stray address.
module pc_counter #(
  parameter int AW    = 2,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          load,
  input  logic          inc,
  input  logic [AW-1:0] load_addr,
  output logic [AW-1:0] pc
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= '0;
    end else if (clear) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_addr;
    end else if (inc) begin
      pc <= (pc == LAST) ? '0 : pc + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, latches the fetched word
// into ir and hands it to execute over a valid/ready handshake.
module fetch_controller
  import proc_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] HALT_OP = WIDTH'(HALT_OP_DEFAULT),
  parameter int               CNT_W   = 16,
  localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [AW-1:0]    imem_addr,
  input  logic [WIDTH-1:0] imem_data,
  output logic [WIDTH-1:0] ir,
  output logic             ir_valid,
  input  logic             ir_ready,
  input  logic             jump_en,
  input  logic [AW-1:0]    jump_addr,
  input  logic             halt_req,
  output logic [AW-1:0]    pc,
  output logic             busy,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

  fetch_state_t state_q, state_d;

  logic accept;
  logic jump_oob;
  logic ir_load;
  logic valid_set;
  logic valid_clr;
  logic pc_clear;
  logic pc_load;
  logic pc_inc;
  logic cnt_inc;
  logic fault_set;
  logic fault_clr;

  assign accept   = ir_valid & ir_ready;
  assign jump_oob = {1'b0, jump_addr} >= DEPTH_V;

  pc_counter #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_pc (
    .clk       (clk),
    .rst       (rst),
    .clear     (pc_clear),
    .load      (pc_load),
    .inc       (pc_inc),
    .load_addr (jump_addr),
    .pc        (pc)
  );

  always_comb begin
    state_d   = state_q;
    ir_load   = 1'b0;
    valid_set = 1'b0;
    valid_clr = 1'b0;
    pc_clear  = 1'b0;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;
    cnt_inc   = 1'b0;
    fault_set = 1'b0;
    fault_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          pc_clear = 1'b1;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        ir_load   = 1'b1;
        valid_set = 1'b1;
        state_d   = ISSUE;
      end
      ISSUE: begin
        // Redirect inputs only matter on the accepting cycle.
        if (accept) begin
          valid_clr = 1'b1;
          cnt_inc   = 1'b1;
          if (halt_req || ir == HALT_OP) begin
            state_d = HALT;
          end else if (jump_en && jump_oob) begin
            fault_set = 1'b1;
            state_d   = HALT;
          end else if (jump_en) begin
            pc_load = 1'b1;
            state_d = FETCH;
          end else begin
            pc_inc  = 1'b1;
            state_d = FETCH;
          end
        end
      end
      HALT: begin
        if (start) begin
          fault_clr = 1'b1;
          pc_clear  = 1'b1;
          state_d   = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ir       <= '0;
      ir_valid <= 1'b0;
      fault    <= 1'b0;
      retired  <= '0;
    end else begin
      state_q <= state_d;
      if (ir_load) begin
        ir <= imem_data;
      end
      if (valid_set) begin
        ir_valid <= 1'b1;
      end else if (valid_clr) begin
        ir_valid <= 1'b0;
      end
      if (fault_set) begin
        fault <= 1'b1;
      end else if (fault_clr) begin
        fault <= 1'b0;
      end
      if (cnt_inc && retired != '1) begin
        retired <= retired + 1'b1;
      end
    end
  end

  assign imem_addr = pc;
  assign busy      = (state_q == FETCH) || (state_q == ISSUE);
  assign halted    = (state_q == HALT);

endmodule
